// File: rtl/qspi_mem_ctrl.sv
// qspi_mem_ctrl: turns single-word core read/write requests into QPI PSRAM transactions on four pads
// Optional feature macro: QSPI_MEM_CTRL_QPI_INIT_EN (send SPI-mode enter-QPI opcode 8'h35 after reset)
// Ports:
//   clock, reset_n           system clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake; req_ready is high only in IDLE
//   req_write/addr/wdata     request fields, latched on accept
//   resp_valid/resp_rdata    one-cycle completion pulse with read data (0 for writes)
//   qspi_sclk, qspi_cs_n     serial clock (system clock / 2) and chip select
//   qspi_dir/out/in          per-pad direction (1 = drive), drive data and sampled data
module qspi_mem_ctrl #(
    parameter int         ADDR_W       = 24,
    parameter int         DUMMY_CYCLES = 6,
    parameter int         CS_HIGH_CLKS = 2,
    parameter logic [7:0] RD_CMD       = 8'hEB,
    parameter logic [7:0] WR_CMD       = 8'h38
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              qspi_sclk,
    output logic              qspi_cs_n,
    output logic [3:0]        qspi_dir,
    output logic [3:0]        qspi_out,
    input  logic [3:0]        qspi_in
);
    localparam int         TXW     = 8 + ADDR_W + 32;
    localparam logic [4:0] CMD_LD  = 5'd1;
    localparam logic [4:0] ADDR_LD = 5'(ADDR_W / 4 - 1);
    localparam logic [4:0] DUM_LD  = 5'(DUMMY_CYCLES - 1);
    localparam logic [4:0] DATA_LD = 5'd7;
    // The IDLE cycle that accepts the next request also keeps cs_n high, so DONE
    // covers the rest of the CS-high gap (but always lasts at least one cycle).
    localparam logic [4:0] DONE_LD = 5'((CS_HIGH_CLKS > 1 ? CS_HIGH_CLKS - 1 : 1) - 1);

    typedef enum logic [3:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE, PRE, INIT, POST} state_t;

`ifdef QSPI_MEM_CTRL_QPI_INIT_EN
    localparam logic [4:0] GAP_LD = 5'(CS_HIGH_CLKS - 1);
    localparam logic [7:0] QPI_EN = 8'h35;
    localparam state_t     RST_ST = PRE;
    localparam logic [4:0] RST_CNT = GAP_LD;
`else
    localparam state_t     RST_ST = IDLE;
    localparam logic [4:0] RST_CNT = 5'd0;
`endif

    state_t           state, state_n;
    logic [4:0]       cnt, cnt_n;
    logic             phase;
    logic             wr;
    logic [TXW-1:0]   tx;
    logic             act;
    logic             last;

    // act: states that run SCLK with cs_n low
`ifdef QSPI_MEM_CTRL_QPI_INIT_EN
    assign act = state inside {CMD, ADDR, DUMMY, DATA, INIT};
`else
    assign act = state inside {CMD, ADDR, DUMMY, DATA};
`endif
    assign last = act && phase && cnt == 5'd0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RST_ST;
            cnt        <= RST_CNT;
            phase      <= 1'b0;
            wr         <= 1'b0;
            tx         <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            phase      <= act ? ~phase : 1'b0;
            resp_valid <= state == DATA && last;
            // tx holds {opcode, addr, wdata}; its top nibble is always the one on the pads
            if (req_valid && req_ready) begin
                tx <= {req_write ? WR_CMD : RD_CMD, req_addr, req_wdata};
                wr <= req_write;
            end else if (phase && state inside {CMD, ADDR, DATA})
                tx <= tx << 4;
            // resp_rdata doubles as the read shift register; cleared so writes report 0
            if (req_valid && req_ready)
                resp_rdata <= '0;
            else if (phase && state == DATA && !wr)
                resp_rdata <= {resp_rdata[27:0], qspi_in};
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = (act && !phase) ? cnt : cnt - 5'd1;
        req_ready = state == IDLE;
        qspi_cs_n = !act;
        qspi_sclk = act && phase;
        qspi_dir  = 4'h0;
        qspi_out  = 4'h0;
        case (state)
            IDLE: if (req_valid) begin
                state_n = CMD;
                cnt_n   = CMD_LD;
            end
            CMD: begin
                qspi_dir = 4'hF;
                qspi_out = tx[TXW-1 -: 4];
                if (last) begin
                    state_n = ADDR;
                    cnt_n   = ADDR_LD;
                end
            end
            ADDR: begin
                qspi_dir = 4'hF;
                qspi_out = tx[TXW-1 -: 4];
                if (last) begin
                    state_n = wr ? DATA : DUMMY;
                    cnt_n   = wr ? DATA_LD : DUM_LD;
                end
            end
            DUMMY: if (last) begin
                state_n = DATA;
                cnt_n   = DATA_LD;
            end
            DATA: begin
                qspi_dir = {4{wr}};
                qspi_out = wr ? tx[TXW-1 -: 4] : 4'h0;
                if (last) begin
                    state_n = DONE;
                    cnt_n   = DONE_LD;
                end
            end
            DONE: if (cnt == 5'd0) state_n = IDLE;
`ifdef QSPI_MEM_CTRL_QPI_INIT_EN
            PRE: if (cnt == 5'd0) begin
                state_n = INIT;
                cnt_n   = 5'd7;
            end
            INIT: begin
                qspi_dir = 4'b0001;
                qspi_out = {3'b000, QPI_EN[cnt[2:0]]};
                if (last) begin
                    state_n = POST;
                    cnt_n   = GAP_LD;
                end
            end
            POST: if (cnt == 5'd0) state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end
endmodule
